// File: rtl/result_writer_pkg.sv
// Shared widths, result count and FSM state encoding for the result writer block.
package result_writer_pkg;
  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 8;
  localparam int NUM_RESULTS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/result_writer_if.sv
// Start request, 2x2 result strobe and memory write port of the result writer.
interface result_writer_if #(
  parameter int ADDR_W = result_writer_pkg::ADDR_W,
  parameter int DATA_W = result_writer_pkg::DATA_W
);
  logic              en;
  logic [ADDR_W-1:0] result_baseaddr;
  logic              c_valid;
  logic [DATA_W-1:0] c11;
  logic [DATA_W-1:0] c12;
  logic [DATA_W-1:0] c21;
  logic [DATA_W-1:0] c22;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d;
  logic              we;
  logic              busy;
  logic              is_done_o;

  modport master (
    output en, result_baseaddr, c_valid, c11, c12, c21, c22,
    input  addr, d, we, busy, is_done_o
  );

  modport slave (
    input  en, result_baseaddr, c_valid, c11, c12, c21, c22,
    output addr, d, we, busy, is_done_o
  );
endinterface

// File: rtl/result_writer_buffer.sv
// Four-entry capture bank holding one set of 2x2 results; index 0 is c11, 3 is c22.
module result_buffer #(
  parameter int DATA_W = result_writer_pkg::DATA_W
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               cap_en,
  input  logic [result_writer_pkg::NUM_RESULTS-1:0][DATA_W-1:0] din,
  input  logic [1:0]                                         sel,
  output logic [DATA_W-1:0]                                  dout
);
  logic [result_writer_pkg::NUM_RESULTS-1:0][DATA_W-1:0] bank;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
    end else if (cap_en) begin
      bank <= din;
    end
  end

  assign dout = bank[sel];
endmodule

// File: rtl/result_writer.sv
// Captures one 2x2 result set and streams it to memory as four consecutive writes.
module result_writer #(
  parameter int ADDR_W = result_writer_pkg::ADDR_W,
  parameter int DATA_W = result_writer_pkg::DATA_W
) (
  input logic            clk,
  input logic            rst,
  result_writer_if.slave bus
);
  import result_writer_pkg::*;

  state_t            state, state_next;
  logic [1:0]        beat, beat_next;
  logic [1:0]        rd_sel;
  logic [ADDR_W-1:0] base, base_next;
  logic [ADDR_W-1:0] addr_p1, addr_next;
  logic [DATA_W-1:0] d_p1, d_next;
  logic [DATA_W-1:0] buf_rd;
  logic              we_p1, we_next;
  logic              cap_en;

  // The beat register tracks the write currently on the bus, so the buffer is read one ahead.
  assign rd_sel = beat + 2'd1;

  result_buffer #(.DATA_W(DATA_W)) u_buffer (
    .clk    (clk),
    .rst    (rst),
    .cap_en (cap_en),
    .din    ({bus.c22, bus.c21, bus.c12, bus.c11}),
    .sel    (rd_sel),
    .dout   (buf_rd)
  );

  always_comb begin
    state_next = state;
    beat_next  = beat;
    base_next  = base;
    addr_next  = addr_p1;
    d_next     = d_p1;
    we_next    = 1'b0;
    cap_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) begin
          base_next  = bus.result_baseaddr;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Beat 0 bypasses the buffer since it is captured on this same edge.
        if (bus.c_valid) begin
          cap_en     = 1'b1;
          beat_next  = 2'd0;
          we_next    = 1'b1;
          addr_next  = base;
          d_next     = bus.c11;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (beat == 2'd3) begin
          state_next = DONE;
        end else begin
          beat_next = rd_sel;
          we_next   = 1'b1;
          addr_next = base + ADDR_W'(rd_sel);
          d_next    = buf_rd;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output register stage (p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= 2'd0;
      base    <= '0;
      addr_p1 <= '0;
      d_p1    <= '0;
      we_p1   <= 1'b0;
    end else begin
      state   <= state_next;
      beat    <= beat_next;
      base    <= base_next;
      addr_p1 <= addr_next;
      d_p1    <= d_next;
      we_p1   <= we_next;
    end
  end

  assign bus.addr      = addr_p1;
  assign bus.d         = d_p1;
  assign bus.we        = we_p1;
  assign bus.busy      = (state == WAIT) || (state == WRITE);
  assign bus.is_done_o = (state == DONE);
endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter ADDR_W, default 6, is the memory address width.
REQ-002 Parameter DATA_W, default 8, is the memory data and result element width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports are clk and rst.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port en, input, 1 bit: start request, sampled in IDLE only.
REQ-007 Port result_baseaddr, input, ADDR_W bits: destination base address, latched on start.
REQ-008 Port c_valid, input, 1 bit: strobe marking c11..c22 as valid this cycle.
REQ-009 Ports c11, c12, c21, c22, input, DATA_W bits each: 2x2 systolic-array results.
REQ-010 Port addr, output, ADDR_W bits: memory write address.
REQ-011 Port d, output, DATA_W bits: memory write data.
REQ-012 Port we, output, 1 bit: memory write enable.
REQ-013 Port busy, output, 1 bit: high from WAIT through the last WRITE cycle.
REQ-014 Port is_done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT, WRITE and DONE.
REQ-016 IDLE transition: on en=1, latch result_baseaddr and go to WAIT.
REQ-017 IDLE with en=0: stay in IDLE.
REQ-018 WAIT transition: on c_valid=1, capture c11, c12, c21, c22 into a 4-entry buffer in the same edge, clear the beat counter and go to WRITE.
REQ-019 WAIT with c_valid=0: hold indefinitely.
REQ-020 WRITE SHALL last exactly 4 cycles, beats 0..3.
REQ-021 In beat k: we=1, addr=(base+k) mod 2^ADDR_W, d=buf[k], with order c11, c12, c21, c22.
REQ-022 After beat 3 the FSM SHALL go to DONE.
REQ-023 DONE SHALL last one cycle with is_done_o=1 and we=0, then return to IDLE unconditionally.
REQ-024 en asserted in DONE SHALL be ignored.
REQ-025 addr, d and we SHALL be registered outputs.
REQ-026 Latency: if c_valid is sampled at edge N, the first write cycle is the cycle after edge N, and is_done_o is high 5 cycles after edge N.
REQ-027 c_valid or c11..c22 changes outside WAIT SHALL be ignored, so the buffer is stable during WRITE.
REQ-028 en or result_baseaddr changes after start SHALL be ignored.
REQ-029 Address wrap: base 62 yields writes to 62, 63, 0, 1.
REQ-030 When we=0, addr and d SHALL hold their last values; we is the only qualifier.
REQ-031 Address arithmetic SHALL be unsigned, truncated to ADDR_W; there is no overflow flag.

Reset
REQ-032 rst=1 at an edge SHALL force state IDLE, beat counter 0, buffer 0, latched base 0, and addr=0, d=0, we=0, busy=0, is_done_o=0, with priority over all other inputs.
REQ-033 Reset in the middle of WRITE SHALL abort the transfer: we=0 from that edge, no is_done_o pulse, and remaining beats are never issued.

Structure
REQ-034 A shared package SHALL hold ADDR_W, DATA_W, NUM_RESULTS=4 and the 2-bit state encoding (IDLE=0, WAIT=1, WRITE=2, DONE=3).
REQ-035 One sub-module, result_buffer, SHALL implement the 4 x DATA_W capture register bank with a capture enable and a 2-bit read select.
REQ-036 The FSM, beat counter and address adder SHALL live in result_writer.

Verification
REQ-037 Basic write: base=0x10, en pulse, then c_valid with c11..c22=0x11, 0x22, 0x33, 0x44 -> writes (0x10, 0x11), (0x11, 0x22), (0x12, 0x33), (0x13, 0x44) on 4 consecutive cycles, then is_done_o for 1 cycle.
REQ-038 Wrap: base=62, results 0xA0..0xA3 -> addresses 62, 63, 0, 1 with data 0xA0..0xA3 in order.
REQ-039 Stable capture: change c11..c22 to 0xFF during WRITE and pulse c_valid again -> written data remains the originally captured values.
REQ-040 Reset mid-operation: assert rst during beat 1 -> we=0 from that edge, no is_done_o, busy=0; a new en then completes normally.
REQ-041 Idle immunity and stall: c_valid pulses while in IDLE -> no writes; en held with c_valid delayed 10 cycles -> busy=1, we=0 throughout, and writes start 1 cycle after c_valid.
REQ-042 en in DONE: hold en=1 through DONE -> FSM returns to IDLE, then restarts from the next IDLE sample, with exactly one is_done_o pulse per transfer.
